nn_layer_sequencer: RTL and testbench

//   Sequences the shared neuron MAC datapath through one MLP inference:
//   two hidden passes (hidden neurons 0..N_PAR-1, then N_PAR..2*N_PAR-1) and one

---
 rtl/nn_layer_sequencer.sv | 153 +++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Control sequencer for the shared MLP neuron MAC datapath: two hidden passes,
// one output pass, then a serial signed arg-max of the output scores into label.
module nn_layer_sequencer #(
  parameter int N_IN    = 62,
  parameter int N_HID   = 20,
  parameter int N_OUT   = 10,
  parameter int N_PAR   = 10,
  parameter int SCORE_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_OUT*SCORE_W-1:0] score_in,
  output logic [1:0]               pass,
  output logic [15:0]              N,
  output logic [15:0]              counter,
  output logic                     acc_clr,
  output logic                     acc_en,
  output logic                     hreg1_en,
  output logic                     hreg2_en,
  output logic                     oreg_en,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               label
);

  // The output pass consumes both hidden halves, so its length is 2*N_PAR == N_HID.
  localparam int OUT_LEN = (N_HID == 2 * N_PAR) ? N_HID : 2 * N_PAR;
  localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_ACC    = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_ARGMAX = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                state_q, state_d;
  logic [1:0]                pass_q, pass_d;
  logic [15:0]               counter_q, counter_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [7:0]                arg_q, arg_d;
  logic [7:0]                label_q, label_d;

  logic [15:0]               macLen;
  logic signed [SCORE_W-1:0] scores [N_OUT];
  logic signed [SCORE_W-1:0] curScore;
  logic                      takeNew;
  logic signed [SCORE_W-1:0] bestNext;
  logic [7:0]                argNext;

  assign macLen = (pass_q == 2'd2) ? 16'(OUT_LEN) : 16'(N_IN);

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      scores[k] = score_in[k*SCORE_W +: SCORE_W];
    end
  end

  // Strict greater-than so that ties keep the earliest (lowest) index.
  assign curScore = scores[idx_q];
  assign takeNew  = (idx_q == '0) || (curScore > best_q);
  assign bestNext = takeNew ? curScore : best_q;
  assign argNext  = takeNew ? 8'(idx_q) : arg_q;

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    counter_d = counter_q;
    idx_d     = idx_q;
    best_d    = best_q;
    arg_d     = arg_q;
    label_d   = label_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          pass_d    = 2'd0;
          counter_d = '0;
        end
      end
      S_CLR: state_d = S_ACC;
      S_ACC: begin
        if (counter_q == macLen - 16'd1) begin
          state_d = S_LATCH;
        end else begin
          counter_d = counter_q + 16'd1;
        end
      end
      S_LATCH: begin
        if (pass_q == 2'd2) begin
          state_d = S_ARGMAX;
          idx_d   = '0;
        end else begin
          state_d   = S_CLR;
          pass_d    = pass_q + 2'd1;
          counter_d = '0;
        end
      end
      S_ARGMAX: begin
        best_d = bestNext;
        arg_d  = argNext;
        if (idx_q == IDX_W'(N_OUT - 1)) begin
          state_d = S_DONE;
          label_d = argNext;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        pass_d    = 2'd0;
        counter_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pass_q    <= 2'd0;
      counter_q <= '0;
      idx_q     <= '0;
      best_q    <= '0;
      arg_q     <= '0;
      label_q   <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      counter_q <= counter_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      arg_q     <= arg_d;
      label_q   <= label_d;
    end
  end

  assign pass     = pass_q;
  assign N        = macLen;
  assign counter  = counter_q;
  assign acc_clr  = (state_q == S_CLR);
  assign acc_en   = (state_q == S_ACC);
  assign hreg1_en = (state_q == S_LATCH) && (pass_q == 2'd0);
  assign hreg2_en = (state_q == S_LATCH) && (pass_q == 2'd1);
  assign oreg_en  = (state_q == S_LATCH) && (pass_q == 2'd2);
  assign busy     = (state_q == S_CLR) || (state_q == S_ACC) ||
                    (state_q == S_LATCH) || (state_q == S_ARGMAX);
  assign done     = (state_q == S_DONE);
  assign label    = label_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: cycle-accurate control trace model
// plus an arg-max reference whose expected labels are queued at start.
module tb_nn_layer_sequencer;

  localparam int N_OUT   = 10;
  localparam int SCORE_W = 16;
  localparam int LAT     = 160;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [N_OUT*SCORE_W-1:0] score_in;
  logic [1:0]               pass;
  logic [15:0]              N;
  logic [15:0]              counter;
  logic                     acc_clr, acc_en, hreg1_en, hreg2_en, oreg_en, busy, done;
  logic [7:0]               label;

  int errors = 0;
  int checks = 0;
  int sbQ[$];
  int lastLabel = 0;

  nn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .score_in(score_in),
    .pass(pass), .N(N), .counter(counter),
    .acc_clr(acc_clr), .acc_en(acc_en), .hreg1_en(hreg1_en), .hreg2_en(hreg2_en),
    .oreg_en(oreg_en), .busy(busy), .done(done), .label(label)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [N_OUT*SCORE_W-1:0] packScores(input int v[N_OUT]);
    logic [N_OUT*SCORE_W-1:0] p;
    for (int k = 0; k < N_OUT; k++) p[k*SCORE_W +: SCORE_W] = SCORE_W'(v[k]);
    return p;
  endfunction

  function automatic int modelArgmax(input logic [N_OUT*SCORE_W-1:0] s);
    logic signed [SCORE_W-1:0] best, cur;
    int arg;
    best = s[SCORE_W-1:0];
    arg  = 0;
    for (int k = 1; k < N_OUT; k++) begin
      cur = s[k*SCORE_W +: SCORE_W];
      if (cur > best) begin
        best = cur;
        arg  = k;
      end
    end
    return arg;
  endfunction

  // Order: {acc_clr, acc_en, hreg1_en, hreg2_en, oreg_en, busy, done}, rel = cycles after start edge.
  function automatic logic [6:0] expCtrl(input int rel);
    logic [6:0] e;
    e[6] = (rel == 0) || (rel == 64) || (rel == 128);
    e[5] = (rel >= 1 && rel <= 62) || (rel >= 65 && rel <= 126) || (rel >= 129 && rel <= 148);
    e[4] = (rel == 63);
    e[3] = (rel == 127);
    e[2] = (rel == 149);
    e[1] = (rel >= 0 && rel <= 159);
    e[0] = (rel == LAT);
    return e;
  endfunction

  function automatic int expPass(input int rel);
    if (rel < 64) return 0;
    if (rel < 128) return 1;
    return 2;
  endfunction

  // Returns -1 where the counter value is not defined (argmax and later).
  function automatic int expCounter(input int rel);
    int loc, len;
    loc = (rel < 64) ? rel : (rel < 128) ? rel - 64 : rel - 128;
    len = (rel < 128) ? 62 : 20;
    if (loc == 0) return 0;
    if (loc <= len) return loc - 1;
    if (loc == len + 1) return len - 1;
    return -1;
  endfunction

  task automatic applyStimulus(input logic [N_OUT*SCORE_W-1:0] scores, input bit noise,
                               input bit holdStart);
    int runStart, rel, expLbl, expCnt;
    int ctrlBad, passBad, cntBad, holdBad;
    bit restarted, finished;
    logic [6:0] got;
    runStart = 0; ctrlBad = 0; passBad = 0; cntBad = 0; holdBad = 0;
    restarted = 0; finished = 0;
    score_in = scores;
    sbQ.push_back(modelArgmax(scores));
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 if (!holdStart) start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      rel = cyc - runStart;
      got = {acc_clr, acc_en, hreg1_en, hreg2_en, oreg_en, busy, done};
      if (rel <= LAT || (holdStart && !restarted && rel == LAT + 1)) begin
        if (got !== expCtrl(rel)) ctrlBad++;
      end
      if (rel <= LAT) begin
        if (int'(pass) !== expPass(rel)) passBad++;
        if (int'(N) !== ((expPass(rel) == 2) ? 20 : 62)) passBad++;
        expCnt = expCounter(rel);
        if (expCnt >= 0 && int'(counter) !== expCnt) cntBad++;
      end
      if (rel < LAT && int'(label) !== lastLabel) holdBad++;
      if (restarted && rel == 0) start = 1'b0;
      if (rel == LAT) begin
        checkOutput("doneAtLatency", int'(done), 1);
        expLbl = sbQ.pop_front();
        checkOutput("label", int'(label), expLbl);
        lastLabel = expLbl;
        if (holdStart && !restarted) restarted = 1'b1;
        else finished = 1'b1;
      end else if (holdStart && restarted && rel == LAT + 1) begin
        runStart = cyc + 1;
        sbQ.push_back(modelArgmax(scores));
      end
      if (noise) start = (rel >= 1 && rel < 150) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (!finished) checkOutput("doneTimeout", 0, 1);
    start = 1'b0;
    checkOutput("ctrlTrace", ctrlBad, 0);
    checkOutput("passAndN", passBad, 0);
    checkOutput("counterSeq", cntBad, 0);
    checkOutput("labelHold", holdBad, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl"}, int'({acc_clr, acc_en, hreg1_en, hreg2_en, oreg_en, busy, done}), 0);
    checkOutput({tag, "_label"}, int'(label), 0);
    checkOutput({tag, "_pass"}, int'(pass), 0);
    checkOutput({tag, "_N"}, int'(N), 62);
    checkOutput({tag, "_counter"}, int'(counter), 0);
  endtask

  task automatic resetMidRun(input logic [N_OUT*SCORE_W-1:0] scores);
    int doneSeen;
    doneSeen = 0;
    score_in = scores;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("midRunPass", int'(pass), 1);
    #2 rst = 1'b0;
    #1 checkResetState("midReset");
    @(posedge clk);
    #1 rst = 1'b1;
    lastLabel = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("noActivityAfterReset", doneSeen, 0);
  endtask

  int sA[N_OUT] = '{5, -3, 100, 7, 100, 0, -32768, 99, 1, 2};
  int sB[N_OUT] = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -1};
  int sC[N_OUT] = '{0, 1, 2, 3, 50, -7, 49, 50, 8, 9};
  int sD[N_OUT] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
  int sE[N_OUT] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 32767};

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    score_in = '0;
    #12 checkResetState("reset");
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(packScores(sA), 1'b0, 1'b0);
    resetMidRun(packScores(sA));
    applyStimulus(packScores(sB), 1'b1, 1'b0);
    applyStimulus(packScores(sC), 1'b0, 1'b1);
    applyStimulus(packScores(sD), 1'b0, 1'b0);
    applyStimulus(packScores(sE), 1'b1, 1'b0);

    checkOutput("scoreboardEmpty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
